// File: rtl/idli_cmp_m_if.sv
// Nibble-serial compare request bus and predicate-file write port for idli_cmp_m.
// Extra accumulate/read-port members exist only when IDLI_CMP_ACCUM_EN is defined.
interface idli_cmp_m_if #(
  parameter int OP_W = 3
);
  logic            i_cmp_start;
  logic            i_cmp_valid;
  logic [OP_W-1:0] i_cmp_op;
  logic [1:0]      i_cmp_pd;
  logic [3:0]      i_cmp_a;
  logic [3:0]      i_cmp_b;
  logic            o_cmp_busy;
  logic [1:0]      o_cmp_pred_wr;
  logic            o_cmp_pred_wr_en;
  logic            o_cmp_pred_wr_data;
`ifdef IDLI_CMP_ACCUM_EN
  logic [1:0]      o_cmp_pred_rd;
  logic            i_cmp_pred_rd_data;
  logic [1:0]      i_cmp_acc;
`endif

  modport master (
    output i_cmp_start, i_cmp_valid, i_cmp_op, i_cmp_pd, i_cmp_a, i_cmp_b,
`ifdef IDLI_CMP_ACCUM_EN
    output i_cmp_pred_rd_data, i_cmp_acc,
    input  o_cmp_pred_rd,
`endif
    input  o_cmp_busy, o_cmp_pred_wr, o_cmp_pred_wr_en, o_cmp_pred_wr_data
  );

  modport slave (
    input  i_cmp_start, i_cmp_valid, i_cmp_op, i_cmp_pd, i_cmp_a, i_cmp_b,
`ifdef IDLI_CMP_ACCUM_EN
    input  i_cmp_pred_rd_data, i_cmp_acc,
    output o_cmp_pred_rd,
`endif
    output o_cmp_busy, o_cmp_pred_wr, o_cmp_pred_wr_en, o_cmp_pred_wr_data
  );
endinterface

// File: rtl/idli_cmp_m.sv
// Bit-serial 16-bit compare producing one predicate-file write per compare.
// Optional IDLI_CMP_ACCUM_EN folds the old predicate value in with AND/OR.
module idli_cmp_m #(
  parameter int NIBBLES = 4,
  parameter int OP_W    = 3
) (
  input  logic          i_cmp_gck,
  input  logic          i_cmp_rst,
  idli_cmp_m_if.slave   cmp
);
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
  localparam logic [1:0]    P3   = 2'b11;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            eq_q, eq_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [1:0]      pd_q, pd_d;
  logic            wr_en_q, wr_en_d;
  logic [1:0]      wr_q, wr_d;
  logic            data_q, data_d;
`ifdef IDLI_CMP_ACCUM_EN
  logic [1:0]      acc_q, acc_d;
`endif

  logic       first, cin, eq_in, eq_nib, n_flag, v_flag, c_flag, res, fin;
  logic [4:0] ch;
  logic [3:0] nb;

  function automatic logic cmp_result(input logic [OP_W-1:0] op, input logic n,
                                      input logic v, input logic c, input logic eq);
    case (op)
      OP_W'(0): cmp_result = eq;
      OP_W'(1): cmp_result = !eq;
      OP_W'(2): cmp_result = n ^ v;
      OP_W'(3): cmp_result = !(n ^ v);
      OP_W'(4): cmp_result = !c;
      OP_W'(5): cmp_result = c;
      default:  cmp_result = 1'b0;
    endcase
  endfunction

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    op_legal = (op <= OP_W'(5));
  endfunction

  // Per-nibble A - B ripple (A + ~B + carry) and flag extraction.
  always_comb begin
    first  = cmp.i_cmp_start && cmp.i_cmp_valid;
    cin    = first ? 1'b1 : carry_q;
    eq_in  = first ? 1'b1 : eq_q;
    nb     = ~cmp.i_cmp_b;
    ch     = 5'b00000;
    ch[0]  = cin;
    for (int i = 0; i < 4; i++) begin
      ch[i+1] = (cmp.i_cmp_a[i] & nb[i]) | (ch[i] & (cmp.i_cmp_a[i] ^ nb[i]));
    end
    n_flag = cmp.i_cmp_a[3] ^ nb[3] ^ ch[3];
    c_flag = ch[4];
    v_flag = ch[3] ^ ch[4];
    eq_nib = eq_in && (cmp.i_cmp_a == cmp.i_cmp_b);
    res    = cmp_result(op_q, n_flag, v_flag, c_flag, eq_nib);
`ifdef IDLI_CMP_ACCUM_EN
    case (acc_q)
      2'b01:   fin = res & cmp.i_cmp_pred_rd_data;
      2'b10:   fin = res | cmp.i_cmp_pred_rd_data;
      default: fin = res;
    endcase
`else
    fin = res;
`endif
  end

  // Next-state: start (from either state) restarts, RUN+valid advances, otherwise stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    eq_d    = eq_q;
    op_d    = op_q;
    pd_d    = pd_q;
    wr_en_d = 1'b0;
    wr_d    = wr_q;
    data_d  = data_q;
`ifdef IDLI_CMP_ACCUM_EN
    acc_d   = acc_q;
`endif
    if (first) begin
      state_d = RUN;
      cnt_d   = CW'(1);
      carry_d = c_flag;
      eq_d    = eq_nib;
      op_d    = cmp.i_cmp_op;
      pd_d    = cmp.i_cmp_pd;
`ifdef IDLI_CMP_ACCUM_EN
      acc_d   = cmp.i_cmp_acc;
`endif
    end else if (state_q == RUN && cmp.i_cmp_valid) begin
      carry_d = c_flag;
      eq_d    = eq_nib;
      if (cnt_q == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        wr_en_d = (pd_q != P3) && op_legal(op_q);
        wr_d    = pd_q;
        data_d  = fin;
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge i_cmp_gck) begin
    if (i_cmp_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      op_q    <= '0;
      pd_q    <= 2'b00;
      wr_en_q <= 1'b0;
      wr_q    <= 2'b00;
      data_q  <= 1'b0;
`ifdef IDLI_CMP_ACCUM_EN
      acc_q   <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
      op_q    <= op_d;
      pd_q    <= pd_d;
      wr_en_q <= wr_en_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
`ifdef IDLI_CMP_ACCUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign cmp.o_cmp_busy         = (state_q == RUN);
  assign cmp.o_cmp_pred_wr      = wr_q;
  assign cmp.o_cmp_pred_wr_en   = wr_en_q;
  assign cmp.o_cmp_pred_wr_data = data_q;
`ifdef IDLI_CMP_ACCUM_EN
  assign cmp.o_cmp_pred_rd      = pd_q;
`endif
endmodule

// File: tb/tb_idli_cmp_m.sv
// Directed self-checking bench for idli_cmp_m; inputs driven and outputs sampled on negedge.
module tb_idli_cmp_m;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  idli_cmp_m_if #(.OP_W(3)) cmp_if ();

  idli_cmp_m #(.NIBBLES(4), .OP_W(3)) dut (
    .i_cmp_gck (clk),
    .i_cmp_rst (rst),
    .cmp       (cmp_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic st, input logic vl, input logic [2:0] op,
                        input logic [1:0] pd, input logic [3:0] a, input logic [3:0] b);
    cmp_if.i_cmp_start = st;
    cmp_if.i_cmp_valid = vl;
    cmp_if.i_cmp_op    = op;
    cmp_if.i_cmp_pd    = pd;
    cmp_if.i_cmp_a     = a;
    cmp_if.i_cmp_b     = b;
  endtask

  task automatic set_idle();
    set_in(1'b0, 1'b0, 3'd0, 2'd0, 4'h0, 4'h0);
  endtask

  // Four back-to-back nibbles; returns one cycle after the final nibble was accepted.
  task automatic cmp4(input string tag, input logic [2:0] op, input logic [1:0] pd,
                      input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 4; i++) begin
      set_in(i == 0, 1'b1, op, pd, a[4*i +: 4], b[4*i +: 4]);
      tick();
      check({tag, "_busy"}, {15'd0, cmp_if.o_cmp_busy}, (i < 3) ? 16'd1 : 16'd0);
      if (i < 3) check({tag, "_nowr"}, {15'd0, cmp_if.o_cmp_pred_wr_en}, 16'd0);
    end
  endtask

  task automatic exp_wr(input string tag, input logic en, input logic [1:0] pd, input logic d);
    check({tag, "_wr_en"}, {15'd0, cmp_if.o_cmp_pred_wr_en}, {15'd0, en});
    if (en) begin
      check({tag, "_wr"}, {14'd0, cmp_if.o_cmp_pred_wr}, {14'd0, pd});
      check({tag, "_data"}, {15'd0, cmp_if.o_cmp_pred_wr_data}, {15'd0, d});
    end
  endtask

  initial begin
    set_idle();
`ifdef IDLI_CMP_ACCUM_EN
    cmp_if.i_cmp_acc          = 2'b00;
    cmp_if.i_cmp_pred_rd_data = 1'b0;
`endif
    repeat (3) tick();
    check("rst_busy", {15'd0, cmp_if.o_cmp_busy}, 16'd0);
    check("rst_wr_en", {15'd0, cmp_if.o_cmp_pred_wr_en}, 16'd0);
    check("rst_wr", {14'd0, cmp_if.o_cmp_pred_wr}, 16'd0);
    check("rst_data", {15'd0, cmp_if.o_cmp_pred_wr_data}, 16'd0);
    rst = 1'b0;
    tick();

    // EQ of equal operands
    cmp4("eq", 3'b000, 2'd1, 16'h1234, 16'h1234);
    exp_wr("eq", 1'b1, 2'd1, 1'b1);
    set_idle();
    tick();
    check("eq_pulse_end", {15'd0, cmp_if.o_cmp_pred_wr_en}, 16'd0);

    // LT signed then LTU back-to-back: second start overlaps the first's write pulse
    cmp4("lt", 3'b010, 2'd2, 16'h8000, 16'h0001);
    exp_wr("lt", 1'b1, 2'd2, 1'b1);
    cmp4("ltu", 3'b100, 2'd0, 16'h8000, 16'h0001);
    exp_wr("ltu", 1'b1, 2'd0, 1'b0);
    cmp4("ge", 3'b011, 2'd1, 16'h7FFF, 16'h8000);
    exp_wr("ge", 1'b1, 2'd1, 1'b1);
    cmp4("geu", 3'b101, 2'd2, 16'h7FFF, 16'h8000);
    exp_wr("geu", 1'b1, 2'd2, 1'b0);
    cmp4("ne_eq", 3'b001, 2'd0, 16'hBEEF, 16'hBEEF);
    exp_wr("ne_eq", 1'b1, 2'd0, 1'b0);
    set_idle();
    tick();

    // LTU with a two-cycle stall after nibble 1
    set_in(1'b1, 1'b1, 3'b100, 2'd0, 4'hF, 4'h0);
    tick();
    check("stall_busy0", {15'd0, cmp_if.o_cmp_busy}, 16'd1);
    set_in(1'b0, 1'b1, 3'b100, 2'd0, 4'hF, 4'h0);
    tick();
    set_in(1'b0, 1'b0, 3'b100, 2'd0, 4'h0, 4'h0);
    tick();
    check("stall_nowr1", {15'd0, cmp_if.o_cmp_pred_wr_en}, 16'd0);
    check("stall_busy1", {15'd0, cmp_if.o_cmp_busy}, 16'd1);
    tick();
    check("stall_nowr2", {15'd0, cmp_if.o_cmp_pred_wr_en}, 16'd0);
    check("stall_busy2", {15'd0, cmp_if.o_cmp_busy}, 16'd1);
    set_in(1'b0, 1'b1, 3'b100, 2'd0, 4'h0, 4'h1);
    tick();
    check("stall_nowr3", {15'd0, cmp_if.o_cmp_pred_wr_en}, 16'd0);
    set_in(1'b0, 1'b1, 3'b100, 2'd0, 4'h0, 4'h0);
    tick();
    exp_wr("stall", 1'b1, 2'd0, 1'b1);
    set_idle();
    tick();

    // Start without valid is ignored
    set_in(1'b1, 1'b0, 3'b000, 2'd1, 4'h0, 4'h0);
    tick();
    check("start_novalid", {15'd0, cmp_if.o_cmp_busy}, 16'd0);

    // P3 destination and reserved opcode: compare runs, no write
    cmp4("p3", 3'b000, 2'd3, 16'hAAAA, 16'hAAAA);
    exp_wr("p3", 1'b0, 2'd3, 1'b1);
    cmp4("rsv", 3'b110, 2'd1, 16'h1111, 16'h2222);
    exp_wr("rsv", 1'b0, 2'd1, 1'b0);
    set_idle();
    tick();

    // Restart at nibble 2 with NE
    set_in(1'b1, 1'b1, 3'b000, 2'd1, 4'h1, 4'h1);
    tick();
    set_in(1'b0, 1'b1, 3'b000, 2'd1, 4'h1, 4'h1);
    tick();
    cmp4("abort", 3'b001, 2'd2, 16'h0000, 16'h0001);
    exp_wr("abort", 1'b1, 2'd2, 1'b1);
    set_idle();
    tick();

    // Reset at nibble 2
    set_in(1'b1, 1'b1, 3'b000, 2'd1, 4'h5, 4'h5);
    tick();
    set_in(1'b0, 1'b1, 3'b000, 2'd1, 4'h5, 4'h5);
    tick();
    set_in(1'b0, 1'b1, 3'b000, 2'd1, 4'h5, 4'h5);
    rst = 1'b1;
    tick();
    check("rstmid_busy", {15'd0, cmp_if.o_cmp_busy}, 16'd0);
    check("rstmid_nowr", {15'd0, cmp_if.o_cmp_pred_wr_en}, 16'd0);
    rst = 1'b0;
    tick();
    check("rstmid_busy2", {15'd0, cmp_if.o_cmp_busy}, 16'd0);
    set_idle();
    tick();
    check("rstmid_nowr2", {15'd0, cmp_if.o_cmp_pred_wr_en}, 16'd0);

    // Reset in the write cycle kills the pulse
    cmp4("rstwr", 3'b000, 2'd1, 16'h4321, 16'h4321);
    exp_wr("rstwr", 1'b1, 2'd1, 1'b1);
    set_idle();
    rst = 1'b1;
    tick();
    check("rstwr_kill", {15'd0, cmp_if.o_cmp_pred_wr_en}, 16'd0);
    rst = 1'b0;
    tick();

`ifdef IDLI_CMP_ACCUM_EN
    cmp_if.i_cmp_pred_rd_data = 1'b0;
    cmp_if.i_cmp_acc          = 2'b01;
    cmp4("acc_and", 3'b000, 2'd1, 16'h5A5A, 16'h5A5A);
    exp_wr("acc_and", 1'b1, 2'd1, 1'b0);
    cmp_if.i_cmp_acc          = 2'b10;
    cmp4("acc_or", 3'b001, 2'd2, 16'h5A5A, 16'h5A5A);
    exp_wr("acc_or", 1'b1, 2'd2, 1'b0);
    cmp4("acc_or_eq", 3'b000, 2'd2, 16'h5A5A, 16'h5A5A);
    check("acc_rd", {14'd0, cmp_if.o_cmp_pred_rd}, 16'd2);
    exp_wr("acc_or_eq", 1'b1, 2'd2, 1'b1);
    cmp_if.i_cmp_acc          = 2'b00;
    set_idle();
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/idli_cmp_m.md
Name: idli_cmp_m

Overview:
Bit-serial compare unit; write-side producer for the predicate register file. Consumes two 16-bit operands as four 4-bit nibbles, LSB nibble first, one nibble per accepted cycle. Evaluates the selected comparison and issues one predicate write (register, enable, data) on the predicate file write port. Sits in the execute slice beside the serial ALU and shares its operand nibble buses.

Parameters:
NIBBLES, 4, nibbles per operand (operand width = 4*NIBBLES)
OP_W, 3, width of comparison opcode

Ports:
i_cmp_gck  input  1  clock
i_cmp_rst  input  1  synchronous active-high reset
i_cmp_start  input  1  qualifies nibble 0 of a new compare; samples op and destination
i_cmp_valid  input  1  nibble valid this cycle (must be high with start)
i_cmp_op  input  OP_W  comparison opcode, sampled on start
i_cmp_pd  input  preg_t (2)  destination predicate, sampled on start
i_cmp_a  input  4  operand A nibble
i_cmp_b  input  4  operand B nibble
o_cmp_busy  output  1  compare in flight (nibbles 1..NIBBLES-1 pending)
o_cmp_pred_wr  output  preg_t (2)  predicate write register
o_cmp_pred_wr_en  output  1  predicate write enable, one-cycle pulse
o_cmp_pred_wr_data  output  1  predicate write data

Behaviour:
- States: IDLE, RUN. Nibble counter cnt_q (log2 NIBBLES bits), carry_q, eq_q, op_q, pd_q.
- Reset: state IDLE, cnt_q 0, o_cmp_busy 0, o_cmp_pred_wr_en 0, o_cmp_pred_wr 0, o_cmp_pred_wr_data 0.
- Opcodes: 000 EQ, 001 NE, 010 LT signed, 011 GE signed, 100 LTU, 101 GEU, 110/111 reserved.
- Arithmetic: per nibble, sum = A + ~B + carry; carry seeded 1 on start. eq accumulates (A==B) across nibbles, seeded 1.
- Final nibble: N = sum[3], V = carry into bit 3 XOR carry out of bit 3, C = carry out. LTU = !C; LT = N ^ V; GE/GEU/NE are inversions of LT/LTU/EQ.
- IDLE + start&valid: latch op/pd, process nibble 0, cnt_q<=1, go RUN. start without valid ignored.
- RUN + valid: process nibble, cnt_q++. On nibble NIBBLES-1: go IDLE, register result.
- RUN + !valid: hold all state (stall); no write.
- Latency: wr_en pulses exactly one cycle after final nibble accepted; wr/wr_data valid only in that cycle, wr_en low otherwise.
- o_cmp_busy high in RUN only.
- Start in RUN: aborts current compare (no write), restarts with new op/pd, treats current nibble as nibble 0.
- Final nibble and new start in the following cycle: both legal; write pulse of first overlaps nibble 0 of second.
- pd == P3: compare runs, wr_en suppressed (P3 hardwired true).
- Reserved opcode: compare runs, wr_en suppressed.
- Reset mid-RUN: return to IDLE, pending write discarded; reset in write cycle kills the pulse.

Optional Feature:
IDLI_CMP_ACCUM_EN: adds ports o_cmp_pred_rd (preg_t, output) and i_cmp_pred_rd_data (1, input), plus i_cmp_acc (2, input, sampled on start: 00 none, 01 AND, 10 OR, 11 reserved=none). o_cmp_pred_rd drives pd_q throughout RUN. On the final nibble the result is combined with i_cmp_pred_rd_data, which is sampled in that cycle; the file's write bypass covers back-to-back compares. Without the macro: no extra ports, result written unmodified.

Test Plan:
- EQ, A=0x1234, B=0x1234, pd=P1, four consecutive valid nibbles -> wr_en one cycle after nibble 3, wr=1, data=1; busy high cycles 1-3.
- LT signed A=0x8000, B=0x0001 -> data=1. LTU with the same operands -> data=0. GE signed A=0x7FFF, B=0x8000 -> data=1.
- LTU A=0x00FF, B=0x0100, valid low for 2 cycles after nibble 1 -> data=1, write delayed 2 cycles, no spurious wr_en.
- EQ with pd=P3, operands equal -> no wr_en. Reserved op 110 -> no wr_en, busy sequence normal.
- Start re-asserted at nibble 2 with NE, A=0x0000/B=0x0001 -> first compare dropped, one write after the new 4 nibbles with data=1; reset asserted at nibble 2 -> no write, busy=0 next cycle.
- ACCUM_EN, AND mode, i_cmp_pred_rd_data=0, EQ of equal operands -> data=0; OR mode -> data=1.
